uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int DBIT_DEFAULT       = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int SB_TICK_DEFAULT    = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q_reg    <= RST_VAL;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data, stop-bit check.
module uart_rx #(
  parameter int DBIT       = uart_pkg::DBIT_DEFAULT,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DEFAULT,
  parameter int SB_TICK    = uart_pkg::SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  import uart_pkg::*;

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  state_t          state_reg, state_next;
  logic [SW-1:0]   s_cnt_reg, s_cnt_next;
  logic [NW-1:0]   n_cnt_reg, n_cnt_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_cnt_reg <= '0;
      n_cnt_reg <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_cnt_reg <= s_cnt_next;
      n_cnt_reg <= n_cnt_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_cnt_next = s_cnt_reg;
    n_cnt_next = n_cnt_reg;
    b_next     = b_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Start detect runs every clk so back-to-back frames need no idle gap.
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_reg == S_HALF) begin
            s_cnt_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_reg == S_LAST) begin
            s_cnt_next = '0;
            b_next     = DBIT'({rx_s, b_reg} >> 1);
            if (n_cnt_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt_reg + 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_reg == S_STOP) begin
            state_next = IDLE;
            s_cnt_next = '0;
            if (rx_s) begin
              dout_next = b_reg;
              done_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        s_cnt_next = '0;
        n_cnt_next = '0;
      end
    endcase
  end

  assign dout         = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = err_reg;

endmodule
